input_port_register: RTL and testbench
======================================

INPUT_PORT_REGISTER -- requirements
Module: input_port_register

Interface
REQ-001 The block SHALL use one clock, MainClock; reset SHALL be MainReset, synchronous and active-high.
REQ-002 MainClock  in  1  system clock; all state updates on its rising edge.
REQ-003 MainReset  in  1  synchronous active-high reset.
REQ-004 In  in  4  external input data, sampled with InStrobe.
REQ-005 InStrobe  in  1  external write strobe; a rising edge requests one capture.
REQ-006 EnableIn  in  1  CPU control; pops the head entry onto IB this cycle.
REQ-007 ClrOvr  in  1  clears InOverrun.
REQ-008 IB  out  4  internal-bus drive; head data while EnableIn && !empty, else 4'b0000 (wired-OR bus, no tristate).
REQ-009 InReady  out  1  high when at least one entry is held.
REQ-010 InFull  out  1  high when both entries are held; tells the external device to hold off.
REQ-011 InAck  out  1  one-cycle pulse confirming an accepted capture.
REQ-012 InOverrun  out  1  sticky flag; a capture was dropped.

Function
REQ-013 Storage SHALL be a 2-entry FIFO, 4 bits per entry, with state EMPTY, ONE, FULL.
REQ-014 A capture event SHALL occur when InStrobe=1 and the previous-cycle InStrobe=0; In SHALL be sampled in that same cycle.
REQ-015 A pop SHALL occur on a cycle with EnableIn=1 and state!=EMPTY; IB SHALL show the head combinationally and the head SHALL be removed at the next edge.
REQ-016 Transitions SHALL be:
- EMPTY+capture->ONE
- ONE+capture->FULL
- ONE+pop->EMPTY
- FULL+pop->ONE
- ONE+capture+pop->ONE (the new entry becomes the head)
- FULL+capture+pop->FULL (no drop)
REQ-017 EMPTY+capture+pop SHALL give ONE with IB=0000 that cycle; there SHALL be no bypass of fresh data onto IB.
REQ-018 A capture in FULL without a pop SHALL be dropped, InOverrun SHALL be set, and FIFO contents SHALL be unchanged.
REQ-019 InAck SHALL be high in the cycle after an accepted capture only; a dropped capture SHALL give no InAck.
REQ-020 EnableIn in EMPTY SHALL give IB=0000 and no state change.
REQ-021 InOverrun SHALL clear on ClrOvr=1; if a drop occurs in the same cycle as ClrOvr, the set SHALL win.
REQ-022 Capture-to-InReady latency SHALL be 1 cycle: strobe rising at edge N gives InReady high after edge N, so the data is poppable in cycle N+1.
REQ-023 FIFO order SHALL be strict; entries SHALL be popped in capture order.

Reset
REQ-024 While MainReset=1, the FIFO SHALL go to EMPTY, InReady=0, InFull=0, InAck=0, InOverrun=0 and IB=0000.
REQ-025 During reset, the previous-strobe register SHALL load the current InStrobe, so a strobe held high through reset release causes no capture.
REQ-026 Reset mid-operation SHALL discard all entries and any pending InAck.

Configuration
REQ-027 Macro INPUT_PORT_SYNC_EN: when defined, InStrobe and In SHALL pass through a 2-flop synchronizer before edge detection, adding 2 cycles to capture latency (InReady at N+3). Synchronizer flops SHALL reset to 0, and the previous-strobe register SHALL then load the synchronized strobe during reset.
REQ-028 Without INPUT_PORT_SYNC_EN, In and InStrobe SHALL be treated as synchronous to MainClock, with the latency given in REQ-022.

Structure
REQ-029 Package input_port_pkg SHALL hold DATA_W=4, DEPTH=2 and the state enum {EMPTY, ONE, FULL}.
REQ-030 Sub-module strobe_edge_detect SHALL hold the optional synchronizer and the previous-strobe register and output a one-cycle capture pulse plus aligned data.

Verification
REQ-031 Reset then a single strobe with In=4'hA: InAck pulses once, InReady=1; EnableIn gives IB=4'hA, then InReady=0.
REQ-032 Strobes carrying 3, 5, 9 with no pop: the first two are accepted with InFull=1; the third gives InOverrun=1 and no InAck; pops return 3 then 5.
REQ-033 FULL with 1, 2 present, then capture 7 plus pop in the same cycle: IB=1, state stays FULL, no overrun; subsequent pops return 2 then 7.
REQ-034 EMPTY with capture 6 plus EnableIn in the same cycle: IB=0 that cycle, InReady=1 next cycle, next pop returns 6.
REQ-035 InStrobe held high across reset release gives no capture; it must fall and rise again before InReady=1.
REQ-036 With INPUT_PORT_SYNC_EN, a strobe rising edge at edge N gives InReady at N+3; ClrOvr coinciding with a drop leaves InOverrun=1.

Source files
------------

// File: rtl/input_port_pkg.sv
// Shared types and sizes for the input port register.
// FIFO geometry and state encoding.
package input_port_pkg;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 2;
  localparam int PTR_W  = 1;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

endpackage

// File: rtl/strobe_edge_detect.sv
// Strobe rising-edge detector with aligned data.
// INPUT_PORT_SYNC_EN adds a 2-flop synchronizer in front.
module strobe_edge_detect
  import input_port_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stb,
  input  logic [DATA_W-1:0] din,
  output logic              cap,
  output logic [DATA_W-1:0] dout
);

  logic e_stb;
  logic prev;

`ifdef INPUT_PORT_SYNC_EN
  logic [1:0]        s_stb;
  logic [DATA_W-1:0] s_d1;
  logic [DATA_W-1:0] s_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_stb <= '0;
      s_d1  <= '0;
      s_d2  <= '0;
    end else begin
      s_stb <= {s_stb[0], stb};
      s_d1  <= din;
      s_d2  <= s_d1;
    end
  end

  assign e_stb = s_stb[1];
  assign dout  = s_d2;
`else
  assign e_stb = stb;
  assign dout  = din;
`endif

  // Tracks the strobe even in reset, so a level held
  // high across reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    prev <= e_stb;
  end

  assign cap = e_stb & ~prev;

endmodule

// File: rtl/input_port_register.sv
// Two-entry input port FIFO feeding a wired-OR internal bus.
// Build option: INPUT_PORT_SYNC_EN (input synchronizer).
module input_port_register
  import input_port_pkg::*;
(
  input  logic              MainClock,
  input  logic              MainReset,
  input  logic [DATA_W-1:0] In,
  input  logic              InStrobe,
  input  logic              EnableIn,
  input  logic              ClrOvr,
  output logic [DATA_W-1:0] IB,
  output logic              InReady,
  output logic              InFull,
  output logic              InAck,
  output logic              InOverrun
);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_idx;
  logic              cap;
  logic [DATA_W-1:0] cap_d;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              ack_q;
  logic              ovr_q;

  strobe_edge_detect u_edge (
    .clk  (MainClock),
    .rst  (MainReset),
    .stb  (InStrobe),
    .din  (In),
    .cap  (cap),
    .dout (cap_d)
  );

  assign pop    = EnableIn & (state != EMPTY) & ~MainReset;
  assign accept = cap & ((state != FULL) | pop);
  assign drop   = cap & (state == FULL) & ~pop;
  // In FULL a write only happens with a pop, so it
  // reuses the slot being vacated by the head.
  assign wr_idx = rd_ptr ^ PTR_W'(state == ONE);

  always_ff @(posedge MainClock) begin
    if (MainReset) begin
      state  <= EMPTY;
      rd_ptr <= '0;
      ack_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (accept) mem[wr_idx] <= cap_d;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      ack_q <= accept;
      if (drop) ovr_q <= 1'b1;
      else if (ClrOvr) ovr_q <= 1'b0;
      unique case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !pop) state <= FULL;
          else if (pop && !accept) state <= EMPTY;
        end
        FULL: if (pop && !accept) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  assign IB        = pop ? mem[rd_ptr] : '0;
  assign InReady   = (state != EMPTY) & ~MainReset;
  assign InFull    = (state == FULL) & ~MainReset;
  assign InAck     = ack_q & ~MainReset;
  assign InOverrun = ovr_q & ~MainReset;

endmodule

// File: tb/tb_input_port_register.sv
// Bench for input_port_register: directed cases plus
// random traffic against a queue-based reference model.
module tb_input_port_register;

  logic       MainClock = 1'b0;
  logic       MainReset = 1'b1;
  logic [3:0] In = 4'h0;
  logic       InStrobe = 1'b0;
  logic       EnableIn = 1'b0;
  logic       ClrOvr = 1'b0;
  logic [3:0] IB;
  logic       InReady;
  logic       InFull;
  logic       InAck;
  logic       InOverrun;

  always #5 MainClock = ~MainClock;

  input_port_register dut (
    .MainClock (MainClock),
    .MainReset (MainReset),
    .In        (In),
    .InStrobe  (InStrobe),
    .EnableIn  (EnableIn),
    .ClrOvr    (ClrOvr),
    .IB        (IB),
    .InReady   (InReady),
    .InFull    (InFull),
    .InAck     (InAck),
    .InOverrun (InOverrun)
  );

`ifdef INPUT_PORT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic [3:0] q[$];
  logic       m_ack = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_prev = 1'b0;
  logic       dl_s[2] = '{1'b0, 1'b0};
  logic [3:0] dl_d[2] = '{4'h0, 4'h0};
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic stb,
                      input logic [3:0] d,
                      input logic en,
                      input logic clr,
                      output logic [3:0] ib_seen);
    logic       es;
    logic [3:0] ed;
    logic       pop, cap, acc, drop;
    int         sz;
    @(negedge MainClock);
    MainReset = rst;
    InStrobe  = stb;
    In        = d;
    EnableIn  = en;
    ClrOvr    = clr;
    #1;
    sz  = q.size();
    pop = !rst && en && sz > 0;
    check("ib", 8'(IB), pop ? 8'(q[0]) : 8'h0);
    check("ready", 8'(InReady), 8'(!rst && sz > 0));
    check("full", 8'(InFull), 8'(!rst && sz == 2));
    check("ack", 8'(InAck), 8'(!rst && m_ack));
    check("ovr", 8'(InOverrun), 8'(!rst && m_ovr));
    ib_seen = IB;
    @(posedge MainClock);
    if (LAT == 0) begin
      es = stb;
      ed = d;
    end else begin
      es = dl_s[1];
      ed = dl_d[1];
    end
    if (rst) begin
      q.delete();
      m_ack  = 1'b0;
      m_ovr  = 1'b0;
      m_prev = es;
      dl_s   = '{1'b0, 1'b0};
      dl_d   = '{4'h0, 4'h0};
    end else begin
      cap  = es && !m_prev;
      acc  = cap && (sz < 2 || pop);
      drop = cap && sz == 2 && !pop;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ed);
      m_ack = acc;
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_prev  = es;
      dl_s[1] = dl_s[0];
      dl_s[0] = stb;
      dl_d[1] = dl_d[0];
      dl_d[0] = d;
    end
  endtask

  task automatic strobe(input logic [3:0] d);
    logic [3:0] ib;
    step(1'b0, 1'b1, d, 1'b0, 1'b0, ib);
    step(1'b0, 1'b0, d, 1'b0, 1'b0, ib);
  endtask

  task automatic idle(input int n);
    logic [3:0] ib;
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ib);
  endtask

  initial begin
    logic [3:0] ib;

    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, ib);
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, ib);

    // single capture and pop
    strobe(4'hA);
    idle(3);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ib);
    check("single_pop", 8'(ib), 8'hA);
    idle(1);

    // overflow and ordering
    strobe(4'h3);
    strobe(4'h5);
    strobe(4'h9);
    idle(3);
    #1 check("ovf_flag", 8'(InOverrun), 8'h1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ib);
    check("ovf_pop1", 8'(ib), 8'h3);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, ib);
    check("ovf_pop2", 8'(ib), 8'h5);
    idle(1);

    // capture plus pop while full
    strobe(4'h1);
    strobe(4'h2);
    idle(3);
    step(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, ib);
    check("full_cp_ib", 8'(ib), 8'h1);
    step(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, ib);
    idle(3);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ib);
    check("full_cp_pop2", 8'(ib), 8'h2);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ib);
    check("full_cp_pop7", 8'(ib), 8'h7);
    #1 check("full_cp_ovr", 8'(InOverrun), 8'h0);

    // capture plus pop while empty: no bypass
    step(1'b0, 1'b1, 4'h6, 1'b1, 1'b0, ib);
    check("empty_cp_ib", 8'(ib), 8'h0);
    step(1'b0, 1'b0, 4'h6, 1'b0, 1'b0, ib);
    idle(3);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ib);
    check("empty_cp_pop", 8'(ib), 8'h6);

    // strobe held high through reset release
    step(1'b1, 1'b1, 4'hC, 1'b0, 1'b0, ib);
    step(1'b1, 1'b1, 4'hC, 1'b0, 1'b0, ib);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 4'hC, 1'b0, 1'b0, ib);
    #1 check("held_ready", 8'(InReady), 8'h0);
    strobe(4'hD);
    strobe(4'hE);
    idle(3);
    #1 check("rearm_ready", 8'(InReady), 8'h1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           1'($urandom),
           4'($urandom),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 10),
           ib);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
